core_lsu: RTL
=============

# core_lsu

Load/store unit of the execution stage. It consumes the ALU result as the effective address and issues one data-memory transaction per load or store over a req/gnt/rvalid bus. It stalls the pipeline until the transaction completes, then returns sign- or zero-extended load data to writeback. Misaligned accesses and illegal encodings never reach the bus; they raise a one-cycle exception pulse.

## Interface
- DATA_WIDTH, 32 (from core_pkg): data and address width; only 32 is supported.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ex_valid  in  1  an instruction is present in EX.
- ex_mem_read / ex_mem_write  in  1 each  the instruction is a load / store.
- ex_funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_rd  in  5  load destination register.
- alu_out  in  DATA_WIDTH  effective address.
- ex_store_data  in  DATA_WIDTH  rs2 value for stores.
- lsu_stall  out  1  pipeline must hold EX and upstream.
- lsu_exc  out  1  one-cycle pulse: misaligned address or illegal access encoding.
- wb_valid  out  1  one-cycle pulse: wb_data/wb_rd are valid.
- wb_rd  out  5  destination register of the completed load.
- wb_data  out  DATA_WIDTH  extended load result.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write request.
- dmem_addr  out  DATA_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  DATA_WIDTH  read data.

## Operation
- FSM states: IDLE, REQ, WAIT.
- A new op is `ex_valid & (ex_mem_read | ex_mem_write)`. It is only considered in IDLE.
- Legality check:
  - Illegal if read and write are both set.
  - Illegal if funct3 is 011, 110 or 111, or if a store uses funct3 100 or 101.
  - Misaligned if a halfword has addr[0]=1 or a word has addr[1:0]≠0.
- Illegal or misaligned op in IDLE:
  - lsu_exc is registered high for the next cycle only.
  - No bus request is made and lsu_stall stays low.
- Legal op in IDLE:
  - Register address, we, be, wdata, rd, funct3 and addr[1:0].
  - Transition to REQ.
- Byte enables and store data:
  - Byte: be = 0001 << addr[1:0], wdata = {4{data[7:0]}}.
  - Halfword: be = 0011 or 1100 (selected by addr[1]), wdata = {2{data[15:0]}}.
  - Word: be = 1111, wdata = data.
- REQ:
  - dmem_req=1, with all dmem_* outputs held stable until gnt.
  - On gnt, a store returns to IDLE and a load moves to WAIT.
- WAIT: on rvalid, return to IDLE and register the writeback.
  - Select the byte/half at offset addr[1:0] (or addr[1] for halves).
  - Sign-extend for B/H, zero-extend for BU/HU.
- dmem_rvalid is ignored outside WAIT.
- Stall: lsu_stall = (IDLE & legal new op) | (REQ & !(gnt & we)) | (REQ & !we) | (WAIT & !rvalid).
  - Stall drops in the completing cycle, so EX advances on the same edge the FSM returns to IDLE.
  - The held op is not re-accepted.
- Stores never assert wb_valid.
- Reset values: state IDLE; all outputs low (dmem_* addr/be/wdata = 0; wb_data=0, wb_rd=0).
- Reset mid-transaction abandons the transaction immediately. dmem_req is low from the cycle after the reset edge, and a late rvalid is ignored.

## Timing
- Store with immediate gnt: cycle 0 accept (stall=1), cycle 1 REQ+gnt (stall=0), cycle 2 IDLE. EX is held for 1 extra cycle.
- Load with immediate gnt and rvalid one cycle later:
  - Cycle 0 accept, cycle 1 REQ+gnt, cycle 2 WAIT+rvalid (stall=0).
  - Cycle 3: wb_valid=1 with data.
- lsu_exc is asserted in the cycle after the offending op is presented.
- Each gnt/rvalid wait cycle adds exactly one stall cycle.
- Maximum of one outstanding transaction; back-to-back ops are separated by at least one IDLE accept cycle.

## Test plan
- SW at 0x100, data 0xDEADBEEF, gnt on first REQ cycle:
  - dmem_addr=0x100, be=1111, we=1, wdata=0xDEADBEEF.
  - lsu_stall high for exactly 1 cycle; no wb_valid.
- SB at 0x203, data 0x000000A5: be=1000, wdata=0xA5A5A5A5. With gnt delayed 3 cycles, stall lasts 4 cycles and req is held stable.
- LB/LBU at 0x102, rdata=0x12F0_3456, rd=7:
  - LB gives wb_data=0xFFFFFFF0; LBU gives 0x000000F0.
  - wb_rd=7; wb_valid is a single pulse one cycle after rvalid.
- LH at 0x102, rdata=0x8001_0000: wb_data=0xFFFF8001. LHU gives 0x00008001.
- LW at 0x101, and SH at 0x003:
  - lsu_exc pulses once for each.
  - dmem_req is never asserted and lsu_stall stays 0.
- Load issued with rst asserted in the WAIT state:
  - After reset, state is IDLE and dmem_req=0.
  - An rvalid arriving 2 cycles later produces no wb_valid.

Source files
------------

// File: rtl/core_lsu_if.sv
// core_lsu_if: data-memory req/gnt/rvalid bus between the LSU (master) and memory (slave).
interface core_lsu_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  req;
   logic                  we;
   logic [DATA_WIDTH-1:0] addr;
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/core_lsu.sv
// core_lsu: load/store unit issuing one data-memory transaction per op, stalling EX until done.
module core_lsu #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic [2:0]            ex_funct3,
   input  logic [4:0]            ex_rd,
   input  logic [DATA_WIDTH-1:0] alu_out,
   input  logic [DATA_WIDTH-1:0] ex_store_data,
   output logic                  lsu_stall,
   output logic                  lsu_exc,
   output logic                  wb_valid,
   output logic [4:0]            wb_rd,
   output logic [DATA_WIDTH-1:0] wb_data,
   core_lsu_if.master            dmem
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]            be_q, be_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [4:0]            rd_q, rd_d;
   logic [2:0]            f3_q, f3_d;
   logic [1:0]            off_q, off_d;
   logic                  exc_q, exc_d;
   logic                  wbv_q, wbv_d;
   logic [4:0]            wb_rd_q, wb_rd_d;
   logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

   logic                  new_op, illegal, misal, accept, sgn;
   logic [3:0]            be_new;
   logic [DATA_WIDTH-1:0] wdata_new, ld_ext;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;

   always_comb begin
      new_op    = ex_valid & (ex_mem_read | ex_mem_write);
      illegal   = (ex_mem_read & ex_mem_write) | (ex_funct3[1:0] == 2'b11) |
                  (ex_funct3[2] & ex_funct3[1]) | (ex_mem_write & ex_funct3[2]);
      misal     = ((ex_funct3[1:0] == 2'b01) & alu_out[0]) |
                  ((ex_funct3[1:0] == 2'b10) & (alu_out[1:0] != 2'b00));
      accept    = (state_q == IDLE) & new_op & ~illegal & ~misal;
      be_new    = ex_funct3[1] ? 4'b1111 : ex_funct3[0] ? (alu_out[1] ? 4'b1100 : 4'b0011)
                                                        : 4'b0001 << alu_out[1:0];
      wdata_new = ex_funct3[1] ? ex_store_data : ex_funct3[0] ? {2{ex_store_data[15:0]}}
                                                              : {4{ex_store_data[7:0]}};
      ld_byte   = dmem.rdata[{off_q, 3'b000} +: 8];
      ld_half   = off_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
      sgn       = ~f3_q[2];
      ld_ext    = f3_q[1] ? dmem.rdata : f3_q[0] ? {{16{sgn & ld_half[15]}}, ld_half}
                                                 : {{24{sgn & ld_byte[7]}}, ld_byte};
      state_d   = accept ? REQ :
                  ((state_q == REQ) & dmem.gnt) ? (we_q ? IDLE : WAIT) :
                  ((state_q == WAIT) & dmem.rvalid) ? IDLE : state_q;
      we_d      = accept ? ex_mem_write : we_q;
      addr_d    = accept ? {alu_out[DATA_WIDTH-1:2], 2'b00} : addr_q;
      be_d      = accept ? be_new : be_q;
      wdata_d   = accept ? wdata_new : wdata_q;
      rd_d      = accept ? ex_rd : rd_q;
      f3_d      = accept ? ex_funct3 : f3_q;
      off_d     = accept ? alu_out[1:0] : off_q;
      exc_d     = (state_q == IDLE) & new_op & (illegal | misal);
      wbv_d     = (state_q == WAIT) & dmem.rvalid;
      wb_rd_d   = wbv_d ? rd_q : wb_rd_q;
      wb_data_d = wbv_d ? ld_ext : wb_data_q;
   end

   // Stall releases in the completing cycle so EX advances on the same edge as the return to IDLE.
   assign lsu_stall   = accept | ((state_q == REQ) & ~(dmem.gnt & we_q)) |
                        ((state_q == WAIT) & ~dmem.rvalid);
   assign lsu_exc     = exc_q;
   assign wb_valid    = wbv_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign dmem.req    = (state_q == REQ);
   assign dmem.we     = we_q;
   assign dmem.addr   = addr_q;
   assign dmem.be     = be_q;
   assign dmem.wdata  = wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         f3_q      <= '0;
         off_q     <= '0;
         exc_q     <= 1'b0;
         wbv_q     <= 1'b0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rd_q      <= rd_d;
         f3_q      <= f3_d;
         off_q     <= off_d;
         exc_q     <= exc_d;
         wbv_q     <= wbv_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end
endmodule
